// File: rtl/ddc_pkg.sv
// Shared DDC datapath constants and a log2 helper for tools without $clog2.
package ddc_pkg;

    localparam int SAMPLE_W           = 48;
    localparam int DEFAULT_FIFO_DEPTH = 256;

    // Smallest r such that 2**r >= value
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo_if.sv
// Sample FIFO handshake bundle: write side, read side, flush and status.
interface sample_fifo_if
    import ddc_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
);
    localparam int AW = clog2(DEPTH);

    logic             clear;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW:0]      level;
    logic             almost_full;
    logic             overflow;

    // Producer/consumer side
    modport master (
        output clear, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid, level, almost_full, overflow
    );

    // FIFO side
    modport slave (
        input  clear, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid, level, almost_full, overflow
    );

endinterface

// File: rtl/sample_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// The read register holds its value when rd_en is low, so it can serve as the
// FIFO output stage. No reset on storage or read register.
module sdp_ram
    import ddc_pkg::*;
#(
    parameter int WIDTH = SAMPLE_W,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port, held while not enabled
    always_ff @(posedge clock) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO between the decimator and the host-link packer.
// The RAM read register doubles as the output register: a read is issued whenever the
// RAM holds an unread word and the head is empty or being popped, so a word written in
// cycle N is presented in cycle N+2 and back-to-back pops stream without bubbles.
module sample_fifo
    import ddc_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_W,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int ALMOST_LVL = 224
) (
    input logic          clock,
    input logic          reset,
    sample_fifo_if.slave fifo
);

    localparam int          AW       = clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST   = (AW+1)'(ALMOST_LVL);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [AW:0]      level_nxt;
    logic             head_valid;
    logic             almost_full_q;
    logic             overflow_q;
    logic [WIDTH-1:0] ram_dout;
    logic             full;
    logic             wr_acc;
    logic             pop;
    logic             rd_en;

    // Handshake decode; clear masks every transfer in its cycle
    always_comb begin
        full      = (level == FULL_LVL);
        wr_acc    = fifo.wr_valid & ~full & ~fifo.clear;
        pop       = head_valid & fifo.rd_ready & ~fifo.clear;
        // rd_ptr != wr_ptr guarantees the read never hits this cycle's write address
        rd_en     = (rd_ptr != wr_ptr) & (~head_valid | fifo.rd_ready) & ~fifo.clear;
        level_nxt = level;
        if (fifo.clear)          level_nxt = '0;
        else if (wr_acc & ~pop)  level_nxt = level + LVL_ONE;
        else if (pop & ~wr_acc)  level_nxt = level - LVL_ONE;
    end

    // Pointers and head-valid bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
        end else if (fifo.clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_valid <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en)  rd_ptr <= rd_ptr + PTR_ONE;
            if (rd_en)    head_valid <= 1'b1;
            else if (pop) head_valid <= 1'b0;
        end
    end

    // Level counter and status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level         <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            level         <= level_nxt;
            almost_full_q <= (level_nxt >= ALMOST);
            if (fifo.clear)                overflow_q <= 1'b0;
            else if (fifo.wr_valid & full) overflow_q <= 1'b1;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (fifo.wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_dout)
    );

    // Head word is zero whenever nothing is presented (covers reset and clear)
    assign fifo.rd_data     = head_valid ? ram_dout : '0;
    assign fifo.rd_valid    = head_valid;
    assign fifo.wr_ready    = ~full;
    assign fifo.level       = level;
    assign fifo.almost_full = almost_full_q;
    assign fifo.overflow    = overflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench for sample_fifo: a queue of accepted words tagged with their write
// cycle is the reference; a word is due at the head two cycles after it was written.
module tb_sample_fifo;
    import ddc_pkg::*;

    localparam int WIDTH  = 48;
    localparam int DEPTH  = 256;
    localparam int ALMOST = 224;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        int               wcyc;
    } ent_t;

    logic clock = 1'b0;
    logic reset;

    sample_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sample_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ALMOST_LVL (ALMOST)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fifo  (bus)
    );

    always #5 clock = ~clock;

    ent_t model_q[$];
    bit   m_ovf;
    int   cyc;
    int   n_vec;
    int   n_err;
    bit   stream_on;
    int   bubbles;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every cycle against the model, then commit this cycle's transfers
    always @(negedge clock) begin
        bit exp_valid;
        bit full;
        ent_t e;
        if (reset !== 1'b1) begin
            exp_valid = (model_q.size() > 0) && (model_q[0].wcyc + 2 <= cyc);
            full      = (model_q.size() == DEPTH);
            check("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
            if (exp_valid) check("rd_data", 64'(bus.rd_data), 64'(model_q[0].data));
            check("level", 64'(bus.level), 64'(model_q.size()));
            check("wr_ready", 64'(bus.wr_ready), 64'(!full));
            check("almost_full", 64'(bus.almost_full), 64'(model_q.size() >= ALMOST));
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
            if (stream_on && !bus.rd_valid) bubbles++;
            if (bus.clear) begin
                model_q.delete();
                m_ovf = 1'b0;
            end else begin
                if (exp_valid && bus.rd_ready) void'(model_q.pop_front());
                if (bus.wr_valid && !full) begin
                    e.data = bus.wr_data;
                    e.wcyc = cyc;
                    model_q.push_back(e);
                end
                if (bus.wr_valid && full) m_ovf = 1'b1;
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge
    task automatic step(input bit wv, input logic [WIDTH-1:0] wd, input bit rr, input bit clr);
        @(posedge clock);
        #1;
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.clear    = clr;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) step(1'b0, '0, rr, 1'b0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_word();
        return WIDTH'({$urandom, $urandom});
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(0));
        check({tag, ".rd_data"}, 64'(bus.rd_data), 64'(0));
        check({tag, ".level"}, 64'(bus.level), 64'(0));
        check({tag, ".wr_ready"}, 64'(bus.wr_ready), 64'(1));
        check({tag, ".almost_full"}, 64'(bus.almost_full), 64'(0));
        check({tag, ".overflow"}, 64'(bus.overflow), 64'(0));
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.clear    = 1'b0;
        m_ovf        = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        // 1: three words through an empty FIFO with the consumer always ready
        step(1'b1, WIDTH'(1), 1'b1, 1'b0);
        step(1'b1, WIDTH'(2), 1'b1, 1'b0);
        step(1'b1, WIDTH'(3), 1'b1, 1'b0);
        idle(6, 1'b1);
        check("t1.level", 64'(bus.level), 64'(0));

        // 2: fill to capacity, then overrun with 0xDEAD and drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i + 16), 1'b0, 1'b0);
        step(1'b1, WIDTH'(48'hDEAD), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t2.overflow", 64'(bus.overflow), 64'(1));
        check("t2.level", 64'(bus.level), 64'(DEPTH));
        check("t2.wr_ready", 64'(bus.wr_ready), 64'(0));
        idle(DEPTH + 4, 1'b1);

        // 3: steady write+pop for 600 cycles with a word already waiting in RAM
        step(1'b1, rnd_word(), 1'b0, 1'b0);
        step(1'b1, rnd_word(), 1'b0, 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(1'b1, rnd_word(), 1'b1, 1'b0);
            stream_on = 1'b1;
        end
        step(1'b0, '0, 1'b1, 1'b0);
        stream_on = 1'b0;
        check("t3.bubbles", 64'(bubbles), 64'(0));
        idle(4, 1'b1);

        // 4: random writes against a 30% ready consumer
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), rnd_word(), ($urandom_range(0, 99) < 30), 1'b0);
        idle(DEPTH + 4, 1'b1);

        // 5: clear with 10 words queued, coincident write and pop ignored
        for (int i = 0; i < 10; i++) step(1'b1, rnd_word(), 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, WIDTH'(48'hBAD), 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t5.level", 64'(bus.level), 64'(0));
        check("t5.rd_valid", 64'(bus.rd_valid), 64'(0));
        check("t5.overflow", 64'(bus.overflow), 64'(0));
        step(1'b1, WIDTH'(48'h5A5A), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t5.first_after_clear", 64'(bus.rd_data), 64'(48'h5A5A));
        idle(3, 1'b1);

        // 6: asynchronous reset in the middle of a burst
        for (int i = 0; i < 20; i++)
            step(1'b1, rnd_word(), ($urandom_range(0, 99) < 30), 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_q.delete();
        m_ovf = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(48'h700 + i), 1'b1, 1'b0);
        idle(6, 1'b1);
        check("t6.level", 64'(bus.level), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
